// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: PC enable, PC source select and IF/ID flush.
// Handles boot hold, redirects, decode stalls and imem wait states.
module fetch_controller #(
  parameter int BOOT_DELAY = 2,
  parameter int MAX_WAIT   = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_D,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Imem_Ready,
  output logic        PC_En,
  output logic        PC_Src,
  output logic [31:0] PC_Target,
  output logic        Flush_F,
  output logic        Instr_Valid,
  output logic        Timeout_Err,
  output logic [31:0] Stall_Cycles
);

  localparam int BW = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_DELAY);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          pend_q, pend_d;
  logic [31:0]   pend_tgt_q, pend_tgt_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic        boot_hold;
  logic        wait_st;
  logic        run_st;
  logic        redir;
  logic        issue;
  logic [31:0] redir_tgt;

  // BOOT with the delay elapsed behaves as RUN for that cycle
  assign boot_hold = (state_q == BOOT) && (boot_cnt_q != BOOT_LAST);
  assign wait_st   = (state_q == WAIT);
  assign run_st    = !boot_hold && !wait_st;

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    PC_En       = 1'b0;
    PC_Src      = 1'b0;
    PC_Target   = '0;
    Flush_F     = 1'b0;
    Instr_Valid = 1'b0;
    redir       = 1'b0;
    issue       = 1'b0;
    redir_tgt   = Branch_Target;
    unique case (1'b1)
      boot_hold: begin
        boot_cnt_d = boot_cnt_q + 1'b1;
      end
      wait_st: begin
        if (!Imem_Ready) begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (Branch_Taken) begin
            pend_d     = 1'b1;
            pend_tgt_d = Branch_Target;
            Flush_F    = 1'b1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          pend_d     = 1'b0;
          if (Branch_Taken) begin
            redir = 1'b1;
          end else if (pend_q) begin
            redir     = 1'b1;
            redir_tgt = pend_tgt_q;
          end else begin
            issue = 1'b1;
          end
        end
      end
      run_st: begin
        state_d = RUN;
        if (Branch_Taken) begin
          redir = 1'b1;
        end else if (!Imem_Ready) begin
          state_d    = WAIT;
          wait_cnt_d = WW'(1);
        end else begin
          issue = 1'b1;
        end
      end
      default: ;
    endcase
    if (redir) begin
      PC_En     = 1'b1;
      PC_Src    = 1'b1;
      PC_Target = redir_tgt;
      Flush_F   = 1'b1;
    end
    if (issue) begin
      PC_En       = !Stall_D;
      Instr_Valid = 1'b1;
    end
    if (wait_cnt_d == WAIT_MAX) begin
      timeout_d = 1'b1;
    end
    if (!boot_hold && !PC_En) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (!RST) begin
      PC_En       = 1'b0;
      PC_Src      = 1'b0;
      PC_Target   = '0;
      Flush_F     = 1'b1;
      Instr_Valid = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Timeout_Err  = timeout_q;
  assign Stall_Cycles = stall_cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller.
// BOOT_DELAY=2, MAX_WAIT=4.
module tb_fetch_controller;

  logic        CLK;
  logic        RST;
  logic        Stall_D;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Imem_Ready;
  logic        PC_En;
  logic        PC_Src;
  logic [31:0] PC_Target;
  logic        Flush_F;
  logic        Instr_Valid;
  logic        Timeout_Err;
  logic [31:0] Stall_Cycles;

  int n_tests;
  int n_fail;

  fetch_controller #(
    .BOOT_DELAY(2),
    .MAX_WAIT  (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Stall_D      (Stall_D),
    .Branch_Taken (Branch_Taken),
    .Branch_Target(Branch_Target),
    .Imem_Ready   (Imem_Ready),
    .PC_En        (PC_En),
    .PC_Src       (PC_Src),
    .PC_Target    (PC_Target),
    .Flush_F      (Flush_F),
    .Instr_Valid  (Instr_Valid),
    .Timeout_Err  (Timeout_Err),
    .Stall_Cycles (Stall_Cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall,
                       input logic br, input logic [31:0] tgt,
                       input logic rdy);
    RST           = rst;
    Stall_D       = stall;
    Branch_Taken  = br;
    Branch_Target = tgt;
    Imem_Ready    = rdy;
    @(negedge CLK);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // reset held for two edges
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rst_pc_en", 32'(PC_En), 32'd0);
    check("rst_flush", 32'(Flush_F), 32'd1);
    check("rst_ivalid", 32'(Instr_Valid), 32'd0);
    check("rst_tgt", PC_Target, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("rst_stall_cnt", Stall_Cycles, 32'd0);
    check("rst_timeout", 32'(Timeout_Err), 32'd0);

    // boot: two held cycles then fetch
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h44, 1'b0);
      check($sformatf("boot%0d_pc_en", i), 32'(PC_En), 32'd0);
      check($sformatf("boot%0d_flush", i), 32'(Flush_F), 32'd0);
      check($sformatf("boot%0d_iv", i), 32'(Instr_Valid), 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("run1_pc_en", 32'(PC_En), 32'd1);
    check("run1_src", 32'(PC_Src), 32'd0);
    check("run1_iv", 32'(Instr_Valid), 32'd1);
    tick();
    check("boot_stall_cnt", Stall_Cycles, 32'd0);

    // decode stall for three cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check($sformatf("stall%0d_pc_en", i), 32'(PC_En), 32'd0);
      check($sformatf("stall%0d_iv", i), 32'(Instr_Valid), 32'd1);
      check($sformatf("stall%0d_flush", i), 32'(Flush_F), 32'd0);
      tick();
    end
    check("stall_cnt3", Stall_Cycles, 32'd3);

    // redirect beats stall
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
    check("br_pc_en", 32'(PC_En), 32'd1);
    check("br_src", 32'(PC_Src), 32'd1);
    check("br_tgt", PC_Target, 32'h40);
    check("br_flush", 32'(Flush_F), 32'd1);
    check("br_iv", 32'(Instr_Valid), 32'd0);
    tick();
    check("br_stall_cnt", Stall_Cycles, 32'd3);

    // memory wait with two redirects held, newest wins
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("w0_pc_en", 32'(PC_En), 32'd0);
    check("w0_iv", 32'(Instr_Valid), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
    check("w1_pc_en", 32'(PC_En), 32'd0);
    check("w1_flush", 32'(Flush_F), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'hC0, 1'b0);
    check("w2_pc_en", 32'(PC_En), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("wend_pc_en", 32'(PC_En), 32'd1);
    check("wend_src", 32'(PC_Src), 32'd1);
    check("wend_tgt", PC_Target, 32'hC0);
    check("wend_flush", 32'(Flush_F), 32'd1);
    check("wend_iv", 32'(Instr_Valid), 32'd0);
    tick();
    check("w_stall_cnt", Stall_Cycles, 32'd6);
    check("w_timeout", 32'(Timeout_Err), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("after_pend_src", 32'(PC_Src), 32'd0);
    check("after_pend_tgt", PC_Target, 32'h0);
    check("after_pend_pc_en", 32'(PC_En), 32'd1);
    tick();

    // six wait cycles: timeout sets and stays
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check($sformatf("to%0d_pc_en", i), 32'(PC_En), 32'd0);
      tick();
      if (i == 2) check("to_early", 32'(Timeout_Err), 32'd0);
      if (i == 4) check("to_set", 32'(Timeout_Err), 32'd1);
    end
    check("to_stall_cnt", Stall_Cycles, 32'd12);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("to_recover_pc_en", 32'(PC_En), 32'd1);
    check("to_recover_src", 32'(PC_Src), 32'd0);
    tick();
    check("to_sticky", 32'(Timeout_Err), 32'd1);

    // reset during a wait with a pending redirect
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("rst2_pc_en", 32'(PC_En), 32'd0);
    check("rst2_flush", 32'(Flush_F), 32'd1);
    tick();
    check("rst2_timeout", 32'(Timeout_Err), 32'd0);
    check("rst2_stall_cnt", Stall_Cycles, 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check($sformatf("reboot%0d_pc_en", i), 32'(PC_En), 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    check("reboot_pc_en", 32'(PC_En), 32'd1);
    check("reboot_src", 32'(PC_Src), 32'd0);
    check("reboot_tgt", PC_Target, 32'h0);
    check("reboot_iv", 32'(Instr_Valid), 32'd1);
    tick();
    check("reboot_stall_cnt", Stall_Cycles, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
